// File: rtl/uart_apb_initiator_if.sv
// Signal bundle around uart_apb_initiator: command channel, response channel
// and the APB register port of one uart_apb peripheral.
// master: the initiator's view. slave: the command source / APB peripheral view.
interface uart_apb_initiator_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  // APB register port (word address only)
  logic              sel;
  logic              en;
  logic              write_control;
  logic [ADDR_W-3:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output sel, en, write_control, addr, write_data,
    input  read_data, ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  sel, en, write_control, addr, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/uart_apb_initiator.sv
// APB initiator for a single uart_apb register port. Accepts one word command
// at a time, runs an APB setup phase then an access phase (with wait states),
// and returns the result on a valid/ready response channel.
// Optional: define APB_INIT_TIMEOUT_EN to abort an access phase after
// TIMEOUT_CYCLES cycles without ready; the response then carries rsp_err=1.
module uart_apb_initiator #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                  clk,
  input logic                  rstn,
  uart_apb_initiator_if.master bus
);

  localparam int PA_W = ADDR_W - 2;

  // SETUP is the cycle in which the setup-phase outputs are being registered;
  // the first ACCESS cycle therefore still shows the setup phase on the bus
  // (en=0), and ready only counts once en is high.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              wr_q, wr_d;
  logic [PA_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic              sel_q, sel_d;
  logic              en_q, en_d;
  logic              wc_q, wc_d;
  logic [PA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_INIT_TIMEOUT_EN
  localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rsp_err_q, rsp_err_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Byte-lane bits of the command address have no meaning on a word port.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.cmd_addr[1:0];

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.sel           = sel_q;
  assign bus.en            = en_q;
  assign bus.write_control = wc_q;
  assign bus.addr          = addr_q;
  assign bus.write_data    = wdata_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
`ifdef APB_INIT_TIMEOUT_EN
  assign bus.rsp_err       = rsp_err_q;
`else
  assign bus.rsp_err       = 1'b0;
`endif

  // State, latched command and every output register; reset is the idle bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      wr_q        <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      sel_q       <= 1'b0;
      en_q        <= 1'b0;
      wc_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_INIT_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      wr_q        <= wr_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      wc_q        <= wc_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_INIT_TIMEOUT_EN
      tmo_q       <= tmo_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Next-state and next-output decode for the command/APB/response sequence.
  always_comb begin
    // NOTE: every target gets a hold default first, so no path infers a latch.
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    wr_d        = wr_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    sel_d       = sel_q;
    en_d        = en_q;
    wc_d        = wc_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_INIT_TIMEOUT_EN
    tmo_d       = tmo_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          wr_d        = bus.cmd_write;
          lat_addr_d  = bus.cmd_addr[ADDR_W-1:2];
          lat_wdata_d = bus.cmd_wdata;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end

      SETUP: begin
        sel_d   = 1'b1;
        en_d    = 1'b0;
        wc_d    = wr_q;
        addr_d  = lat_addr_q;
        wdata_d = wr_q ? lat_wdata_q : '0;
        state_d = ACCESS;
`ifdef APB_INIT_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end

      ACCESS: begin
        if (!en_q) begin
          en_d = 1'b1;
        end else if (bus.ready) begin
          sel_d       = 1'b0;
          en_d        = 1'b0;
          wc_d        = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? '0 : bus.read_data;
          state_d     = RESP;
`ifdef APB_INIT_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          // Peripheral never answered: release the bus and report the abort.
          sel_d       = 1'b0;
          en_d        = 1'b0;
          wc_d        = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_d       = tmo_q + 1'b1;
`endif
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_apb_initiator.sv
// Directed bench for uart_apb_initiator: reset, write, read with wait states,
// response backpressure, back-to-back commands, access timeout (both builds)
// and reset in the middle of an access phase.
module tb_uart_apb_initiator;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_apb_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  uart_apb_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and holds it until the handshake edge has passed.
  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [31:0] d, output bit ok);
    ok = 1'b0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = w;
    bus_if.cmd_addr  = a;
    bus_if.cmd_wdata = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus_if.cmd_ready;
      tick();
    end
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cycles, output int cycles);
    cycles = 0;
    while (!bus_if.rsp_valid && cycles < max_cycles) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) tick();
    n_checks++; if ({bus_if.cmd_ready, bus_if.sel, bus_if.en, bus_if.write_control, bus_if.rsp_valid, bus_if.rsp_err} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 100000", {bus_if.cmd_ready, bus_if.sel, bus_if.en, bus_if.write_control, bus_if.rsp_valid, bus_if.rsp_err}); end
    n_checks++; if (bus_if.addr !== 10'h000) begin n_fail++; $display("FAIL reset_addr: got %h expected 000", bus_if.addr); end
    n_checks++; if (bus_if.write_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", bus_if.write_data); end
    n_checks++; if (bus_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus_if.rsp_rdata); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    bit ok;
    bus_if.ready = 1'b1;
    bus_if.rsp_ready = 1'b0;
    send_cmd(1'b1, 12'h010, 32'd16, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got %b expected 1", ok); end
    n_checks++; if ({bus_if.cmd_ready, bus_if.sel} !== 2'b00) begin n_fail++; $display("FAIL wr_accepted: cmd_ready/sel got %b expected 00", {bus_if.cmd_ready, bus_if.sel}); end
    tick();
    n_checks++; if ({bus_if.sel, bus_if.en, bus_if.write_control, bus_if.rsp_valid} !== 4'b1010) begin
      n_fail++; $display("FAIL wr_setup_ctrl: sel/en/wc/rsp_valid got %b expected 1010", {bus_if.sel, bus_if.en, bus_if.write_control, bus_if.rsp_valid}); end
    n_checks++; if ({bus_if.addr, bus_if.write_data} !== {10'h004, 32'd16}) begin
      n_fail++; $display("FAIL wr_setup_bus: addr=%h wdata=%0d expected 004/16", bus_if.addr, bus_if.write_data); end
    tick();
    n_checks++; if ({bus_if.sel, bus_if.en, bus_if.write_control, bus_if.rsp_valid, bus_if.addr, bus_if.write_data} !== {4'b1110, 10'h004, 32'd16}) begin
      n_fail++; $display("FAIL wr_access: sel/en/wc/rv=%b addr=%h wdata=%0d expected 1110/004/16", {bus_if.sel, bus_if.en, bus_if.write_control, bus_if.rsp_valid}, bus_if.addr, bus_if.write_data); end
    tick();
    n_checks++; if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL wr_rsp: valid/err=%b rdata=%h expected 10/0", {bus_if.rsp_valid, bus_if.rsp_err}, bus_if.rsp_rdata); end
    n_checks++; if ({bus_if.sel, bus_if.en, bus_if.write_control, bus_if.addr, bus_if.write_data} !== {3'b000, 10'h0, 32'h0}) begin
      n_fail++; $display("FAIL wr_bus_idle: sel/en/wc=%b addr=%h wdata=%h expected all 0", {bus_if.sel, bus_if.en, bus_if.write_control}, bus_if.addr, bus_if.write_data); end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    n_checks++; if ({bus_if.rsp_valid, bus_if.cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL wr_done: rsp_valid/cmd_ready got %b expected 01", {bus_if.rsp_valid, bus_if.cmd_ready}); end
  endtask

  task automatic test_read_wait();
    bit ok;
    bus_if.ready = 1'b0;
    bus_if.read_data = 32'h7;
    send_cmd(1'b0, 12'h004, 32'hDEAD_BEEF, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_accept: got %b expected 1", ok); end
    tick();
    n_checks++; if ({bus_if.sel, bus_if.en, bus_if.write_control, bus_if.addr, bus_if.write_data} !== {3'b100, 10'h001, 32'h0}) begin
      n_fail++; $display("FAIL rd_setup: sel/en/wc=%b addr=%h wdata=%h expected 100/001/0", {bus_if.sel, bus_if.en, bus_if.write_control}, bus_if.addr, bus_if.write_data); end
    for (int c = 2; c <= 7; c++) begin
      tick();
      n_checks++; if ({bus_if.sel, bus_if.en, bus_if.write_control, bus_if.rsp_valid, bus_if.addr} !== {4'b1100, 10'h001}) begin
        n_fail++; $display("FAIL rd_wait_%0d: sel/en/wc/rv=%b addr=%h expected 1100/001", c, {bus_if.sel, bus_if.en, bus_if.write_control, bus_if.rsp_valid}, bus_if.addr); end
    end
    bus_if.ready = 1'b1;
    bus_if.read_data = 32'h2;
    tick();
    bus_if.ready = 1'b0;
    n_checks++; if ({bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.sel} !== {1'b1, 32'h2, 1'b0}) begin
      n_fail++; $display("FAIL rd_rsp: valid=%b rdata=%h sel=%b expected 1/2/0", bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.sel); end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    bus_if.ready = 1'b1;
    bus_if.read_data = 32'hA5;
    send_cmd(1'b0, 12'h00C, 32'h0, ok);
    wait_rsp(10, cyc);
    n_checks++; if ({ok, bus_if.rsp_valid, cyc[3:0]} !== {2'b11, 4'd3}) begin
      n_fail++; $display("FAIL bp_first_rsp: ok/valid=%b latency=%0d expected 11/3", {ok, bus_if.rsp_valid}, cyc); end
    bus_if.read_data = 32'hFF;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = 1'b1;
    bus_if.cmd_addr  = 12'h008;
    bus_if.cmd_wdata = 32'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if ({bus_if.rsp_valid, bus_if.cmd_ready, bus_if.sel, bus_if.rsp_rdata} !== {3'b100, 32'hA5}) begin
        n_fail++; $display("FAIL bp_hold_%0d: valid/cmd_ready/sel=%b rdata=%h expected 100/a5", i, {bus_if.rsp_valid, bus_if.cmd_ready, bus_if.sel}, bus_if.rsp_rdata); end
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    n_checks++; if ({bus_if.rsp_valid, bus_if.cmd_ready, bus_if.sel} !== 3'b010) begin
      n_fail++; $display("FAIL bp_release: valid/cmd_ready/sel got %b expected 010", {bus_if.rsp_valid, bus_if.cmd_ready, bus_if.sel}); end
    tick();
    bus_if.cmd_valid = 1'b0;
    n_checks++; if (bus_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: cmd_ready got %b expected 0", bus_if.cmd_ready); end
    tick();
    n_checks++; if ({bus_if.sel, bus_if.write_control, bus_if.addr, bus_if.write_data} !== {2'b11, 10'h002, 32'd7}) begin
      n_fail++; $display("FAIL bp_second_setup: sel/wc=%b addr=%h wdata=%0d expected 11/002/7", {bus_if.sel, bus_if.write_control}, bus_if.addr, bus_if.write_data); end
    wait_rsp(10, cyc);
    n_checks++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_rsp: rsp_valid got %b expected 1", bus_if.rsp_valid); end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] a [4];
    logic [31:0] d [4];
    logic [11:0] cur_a;
    int issued, done, rises, rsps;
    logic prev_sel, acc;
    a = '{12'h010, 12'h008, 12'h004, 12'h000};
    d = '{32'd16, 32'd0, 32'd1, 32'd53};
    issued = 0; done = 0; rises = 0; rsps = 0; prev_sel = 1'b0;
    bus_if.ready = 1'b1;
    bus_if.rsp_ready = 1'b1;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = 1'b1;
    bus_if.cmd_addr  = a[0];
    bus_if.cmd_wdata = d[0];
    for (int cyc = 0; cyc < 80 && rsps < 4; cyc++) begin
      acc = bus_if.cmd_valid && bus_if.cmd_ready;
      if (bus_if.sel && !prev_sel) rises++;
      if (bus_if.sel && bus_if.en && done < 4) begin
        cur_a = a[done];
        n_checks++; if ({bus_if.write_control, bus_if.addr, bus_if.write_data} !== {1'b1, cur_a[11:2], d[done]}) begin
          n_fail++; $display("FAIL b2b_xfer_%0d: wc=%b addr=%h wdata=%0d expected 1/%h/%0d", done, bus_if.write_control, bus_if.addr, bus_if.write_data, cur_a[11:2], d[done]); end
        done++;
      end
      if (bus_if.rsp_valid) rsps++;
      prev_sel = bus_if.sel;
      tick();
      if (acc) begin
        issued++;
        if (issued < 4) begin
          bus_if.cmd_addr  = a[issued];
          bus_if.cmd_wdata = d[issued];
        end else begin
          bus_if.cmd_valid = 1'b0;
        end
      end
    end
    bus_if.cmd_valid = 1'b0;
    bus_if.rsp_ready = 1'b0;
    n_checks++; if (done !== 4) begin n_fail++; $display("FAIL b2b_xfers: got %0d expected 4", done); end
    n_checks++; if (rises !== 4) begin n_fail++; $display("FAIL b2b_sel_rises: got %0d expected 4", rises); end
    n_checks++; if ({issued[3:0], rsps[3:0]} !== {4'd4, 4'd4}) begin n_fail++; $display("FAIL b2b_cmd_rsp: issued=%0d rsps=%0d expected 4/4", issued, rsps); end
  endtask

  task automatic test_timeout();
    bit ok;
    bus_if.ready = 1'b0;
    bus_if.rsp_ready = 1'b0;
    send_cmd(1'b0, 12'h014, 32'h0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_accept: got %b expected 1", ok); end
`ifdef APB_INIT_TIMEOUT_EN
    repeat (9) tick();
    n_checks++; if ({bus_if.rsp_valid, bus_if.en} !== 2'b01) begin
      n_fail++; $display("FAIL tmo_before: rsp_valid/en got %b expected 01", {bus_if.rsp_valid, bus_if.en}); end
    tick();
    n_checks++; if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.sel, bus_if.en, bus_if.rsp_rdata} !== {4'b1100, 32'h0}) begin
      n_fail++; $display("FAIL tmo_abort: valid/err/sel/en=%b rdata=%h expected 1100/0", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.sel, bus_if.en}, bus_if.rsp_rdata); end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
`else
    repeat (100) tick();
    n_checks++; if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.sel, bus_if.en} !== 4'b0011) begin
      n_fail++; $display("FAIL tmo_still_waiting: valid/err/sel/en got %b expected 0011", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.sel, bus_if.en}); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
`endif
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    int cyc;
    bus_if.ready = 1'b0;
    bus_if.rsp_ready = 1'b0;
    send_cmd(1'b0, 12'h008, 32'h0, ok);
    repeat (3) tick();
    n_checks++; if ({ok, bus_if.sel, bus_if.en} !== 3'b111) begin
      n_fail++; $display("FAIL rst_in_access: ok/sel/en got %b expected 111", {ok, bus_if.sel, bus_if.en}); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if ({bus_if.sel, bus_if.en, bus_if.rsp_valid, bus_if.cmd_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL rst_async: sel/en/rv/cmd_ready got %b expected 0001", {bus_if.sel, bus_if.en, bus_if.rsp_valid, bus_if.cmd_ready}); end
    tick();
    n_checks++; if ({bus_if.sel, bus_if.en, bus_if.rsp_valid, bus_if.cmd_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL rst_next_cycle: sel/en/rv/cmd_ready got %b expected 0001", {bus_if.sel, bus_if.en, bus_if.rsp_valid, bus_if.cmd_ready}); end
    rstn = 1'b1;
    tick();
    bus_if.ready = 1'b1;
    bus_if.read_data = 32'h3C;
    send_cmd(1'b0, 12'h008, 32'h0, ok);
    wait_rsp(10, cyc);
    n_checks++; if ({ok, bus_if.rsp_valid, bus_if.rsp_rdata, cyc[3:0]} !== {2'b11, 32'h3C, 4'd3}) begin
      n_fail++; $display("FAIL rst_recover: ok/valid=%b rdata=%h latency=%0d expected 11/3c/3", {ok, bus_if.rsp_valid}, bus_if.rsp_rdata, cyc); end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    n_checks++; if ({bus_if.rsp_valid, bus_if.cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_recover_done: rsp_valid/cmd_ready got %b expected 01", {bus_if.rsp_valid, bus_if.cmd_ready}); end
  endtask

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_wdata = '0;
    bus_if.rsp_ready = 1'b0;
    bus_if.read_data = '0;
    bus_if.ready     = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
